// File: rtl/soc_dbg_master_pkg.sv
// Shared definitions for the debug bus initiator: protocol byte codes,
// FSM state encoding and small helpers.
package soc_dbg_master_pkg;

  localparam logic [7:0] CMD_RD      = 8'h01;
  localparam logic [7:0] CMD_WR      = 8'h02;

  localparam logic [7:0] RSP_RD      = 8'hA1;
  localparam logic [7:0] RSP_WR      = 8'hA2;
  localparam logic [7:0] RSP_BADCMD  = 8'hEE;
  localparam logic [7:0] RSP_TIMEOUT = 8'hEF;

  // Response lengths in bytes: status only, or status plus a data word.
  localparam logic [2:0] RSP_LEN_SHORT = 3'd1;
  localparam logic [2:0] RSP_LEN_LONG  = 3'd5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    REQ  = 3'd3,
    BUS  = 3'd4,
    RESP = 3'd5
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/soc_dbg_master_if.sv
// Byte-stream and memory-bus signals of the debug initiator, bundled so the
// master and its environment connect through a single port.
interface soc_dbg_master_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_req;
  logic        i_gnt;
  logic        o_stb;
  logic        o_rw;
  logic [31:0] o_addr;
  logic [31:0] o_dtw;
  logic        i_ack;
  logic [31:0] i_dtr;
  logic        o_busy;
  logic        o_rx_drop;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_gnt, i_ack, i_dtr,
    output o_tx_data, o_tx_valid, o_req, o_stb, o_rw, o_addr, o_dtw,
           o_busy, o_rx_drop
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_gnt, i_ack, i_dtr,
    input  o_tx_data, o_tx_valid, o_req, o_stb, o_rw, o_addr, o_dtw,
           o_busy, o_rx_drop
  );
endinterface

// File: rtl/soc_dbg_master_txser.sv
// Response serialiser: takes up to five bytes (left-justified in 40 bits) and
// sends them MSB-first over a valid/ready byte interface.
module soc_dbg_txser (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [39:0] load_data,
  input  logic [2:0]  load_len,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic        done
);

  logic [39:0] shift_reg;
  logic [2:0]  left_reg;
  logic        valid_reg;
  logic        fire;

  assign fire = valid_reg & tx_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      left_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      left_reg  <= load_len;
      valid_reg <= 1'b1;
    end else if (fire) begin
      shift_reg <= {shift_reg[31:0], 8'h00};
      left_reg  <= left_reg - 3'd1;
      if (left_reg == 3'd1) valid_reg <= 1'b0;
    end
  end

  assign tx_data  = shift_reg[39:32];
  assign tx_valid = valid_reg;
  // Combinational so the parent FSM leaves RESP on the same edge valid drops.
  assign done     = fire & (left_reg == 3'd1);

endmodule

// File: rtl/soc_dbg_master.sv
// Debug bus initiator: decodes RD/WR byte frames, performs one bus cycle via
// the arbiter req/gnt handshake, and returns a status/data byte response.
module soc_dbg_master
  import soc_dbg_master_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  soc_dbg_master_if.master  bus
);

  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT);

  state_t             state_reg, state_next;
  logic [1:0]         cnt_reg, cnt_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        dtw_reg, dtw_next;
  logic               rw_reg, rw_next;
  logic               stb_reg, stb_next;
  logic               drop_reg, drop_next;
  logic [TO_BITS-1:0] to_reg, to_next;

  logic               req;
  logic               to_hit;
  logic               ld;
  logic [39:0]        ld_data;
  logic [2:0]         ld_len;
  logic               tx_done;

  assign to_hit = (to_reg == TO_LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      dtw_reg   <= '0;
      rw_reg    <= 1'b0;
      stb_reg   <= 1'b0;
      drop_reg  <= 1'b0;
      to_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      dtw_reg   <= dtw_next;
      rw_reg    <= rw_next;
      stb_reg   <= stb_next;
      drop_reg  <= drop_next;
      to_reg    <= to_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    dtw_next   = dtw_reg;
    rw_next    = rw_reg;
    to_next    = to_reg;
    stb_next   = 1'b0;
    drop_next  = 1'b0;
    req        = 1'b0;
    ld         = 1'b0;
    ld_data    = '0;
    ld_len     = RSP_LEN_SHORT;

    case (state_reg)
      IDLE: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data == CMD_RD || bus.i_rx_data == CMD_WR) begin
            rw_next    = (bus.i_rx_data == CMD_WR);
            cnt_next   = '0;
            state_next = ADDR;
          end else begin
            ld         = 1'b1;
            ld_data    = {RSP_BADCMD, 32'h0};
            state_next = RESP;
          end
        end
      end
      ADDR: begin
        if (bus.i_rx_valid) begin
          addr_next = {addr_reg[23:0], bus.i_rx_data};
          cnt_next  = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = rw_reg ? DATA : REQ;
        end
      end
      DATA: begin
        if (bus.i_rx_valid) begin
          dtw_next = {dtw_reg[23:0], bus.i_rx_data};
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = REQ;
        end
      end
      REQ: begin
        req       = 1'b1;
        drop_next = bus.i_rx_valid;
        to_next   = '0;
        if (bus.i_gnt) begin
          stb_next   = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        drop_next = bus.i_rx_valid;
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (bus.i_ack) begin
          ld         = 1'b1;
          ld_data    = rw_reg ? {RSP_WR, 32'h0} : {RSP_RD, bus.i_dtr};
          ld_len     = rw_reg ? RSP_LEN_SHORT : RSP_LEN_LONG;
          state_next = RESP;
        end else if (to_hit) begin
          ld         = 1'b1;
          ld_data    = {RSP_TIMEOUT, 32'h0};
          state_next = RESP;
        end else begin
          req     = 1'b1;
          to_next = to_reg + 1'b1;
        end
      end
      RESP: begin
        drop_next = bus.i_rx_valid;
        if (tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  soc_dbg_txser u_txser (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ld),
    .load_data (ld_data),
    .load_len  (ld_len),
    .tx_data   (bus.o_tx_data),
    .tx_ready  (bus.i_tx_ready),
    .tx_valid  (bus.o_tx_valid),
    .done      (tx_done)
  );

  assign bus.o_req     = req;
  assign bus.o_stb     = stb_reg;
  assign bus.o_rw      = rw_reg;
  assign bus.o_addr    = word_align(addr_reg);
  assign bus.o_dtw     = dtw_reg;
  assign bus.o_busy    = (state_reg != IDLE);
  assign bus.o_rx_drop = drop_reg;

endmodule

// File: tb/tb_soc_dbg_master.sv
// Self-checking bench for soc_dbg_master: directed scenarios plus randomized
// frames checked against a transaction-level model of the byte protocol.
module tb_soc_dbg_master;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  soc_dbg_master_if dbg();

  soc_dbg_master #(.TIMEOUT(TO), .TO_BITS(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dbg)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int txn_id = 0;

  // Agent configuration
  int          gnt_delay, ack_delay, ready_mode;
  logic [31:0] ack_dtr;

  // Observations gathered by the agents
  logic [7:0]  got_q[$];
  int          stb_count, drop_count, req_drop_at, ack_cd, req_hi, since_stb, cyc, stb_cyc;
  bit          watching, pending_gnt, prev_stall;
  logic [7:0]  prev_data;
  logic [31:0] cap_addr, cap_dtw;
  logic        cap_rw;

  task automatic clear_obs();
    got_q.delete();
    stb_count = 0; drop_count = 0; req_drop_at = -1; ack_cd = 0;
    watching = 0; pending_gnt = 0; stb_cyc = -1;
    cap_addr = '0; cap_dtw = '0; cap_rw = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] fr[9], input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      dbg.i_rx_data = fr[i];
      dbg.i_rx_valid = 1'b1;
    end
    @(posedge clk); #1;
    dbg.i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!dbg.o_busy) begin ok = 1; break; end
    end
  endtask

  task automatic run_txn(input logic [7:0] fr[9], input int n, output bit done);
    send_frame(fr, n);
    wait_idle(done);
    txn_id++;
    $display("txn %0d: cmd %02h len %0d stb %0d resp_bytes %0d first %02h",
             txn_id, fr[0], n, stb_count, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
  endtask

  // Protocol-level reference: what one frame should produce on bus and tx.
  task automatic model_txn(input logic [7:0] fr[9], input int ackd, input logic [31:0] dtr,
                           output int e_stb, output logic [31:0] e_addr, output logic [31:0] e_dtw,
                           output logic e_rw, output logic [7:0] e_rsp[5], output int e_n);
    e_stb = 0; e_addr = '0; e_dtw = '0; e_rw = 1'b0; e_n = 1;
    for (int i = 0; i < 5; i++) e_rsp[i] = 8'h00;
    if (fr[0] != 8'h01 && fr[0] != 8'h02) begin
      e_rsp[0] = 8'hEE;
      return;
    end
    e_stb  = 1;
    e_rw   = (fr[0] == 8'h02);
    e_addr = {fr[1], fr[2], fr[3], fr[4]} & 32'hFFFF_FFFC;
    e_dtw  = {fr[5], fr[6], fr[7], fr[8]};
    if (ackd < 1 || ackd > TO) e_rsp[0] = 8'hEF;
    else if (e_rw) e_rsp[0] = 8'hA2;
    else begin
      e_rsp = '{8'hA1, dtr[31:24], dtr[23:16], dtr[15:8], dtr[7:0]};
      e_n = 5;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (dbg.o_busy !== 1'b0)     $display("FAIL reset_busy got %0b want 0", dbg.o_busy); else pass_cnt++;
    total_cnt++; if (dbg.o_req !== 1'b0)      $display("FAIL reset_req got %0b want 0", dbg.o_req); else pass_cnt++;
    total_cnt++; if (dbg.o_stb !== 1'b0)      $display("FAIL reset_stb got %0b want 0", dbg.o_stb); else pass_cnt++;
    total_cnt++; if (dbg.o_tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0b want 0", dbg.o_tx_valid); else pass_cnt++;
    total_cnt++; if (dbg.o_addr !== 32'h0)    $display("FAIL reset_addr got %08h want 0", dbg.o_addr); else pass_cnt++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rd();
    logic [7:0] fr[9] = '{8'h01, 8'h00, 8'h00, 8'h80, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp[5] = '{8'hA1, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    bit done;
    clear_obs(); gnt_delay = 0; ack_delay = 2; ack_dtr = 32'hDEADBEEF; ready_mode = 0;
    run_txn(fr, 5, done);
    total_cnt++; if (!done) $display("FAIL rd_idle got busy want idle"); else pass_cnt++;
    total_cnt++; if (stb_count !== 1) $display("FAIL rd_stb_count got %0d want 1", stb_count); else pass_cnt++;
    total_cnt++; if (cap_rw !== 1'b0) $display("FAIL rd_rw got %0b want 0", cap_rw); else pass_cnt++;
    total_cnt++; if (cap_addr !== 32'h00008010) $display("FAIL rd_addr got %08h want 00008010", cap_addr); else pass_cnt++;
    total_cnt++; if (req_drop_at !== 2) $display("FAIL rd_req_drop got %0d want 2", req_drop_at); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 5) $display("FAIL rd_resp_len got %0d want 5", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== exp[i]) $display("FAIL rd_resp_byte%0d got %02h want %02h", i, got_q[i], exp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_wr();
    logic [7:0] fr[9] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h07, 8'h12, 8'h34, 8'h56, 8'h78};
    bit done;
    clear_obs(); gnt_delay = 0; ack_delay = 1; ack_dtr = 32'h0; ready_mode = 0;
    run_txn(fr, 9, done);
    total_cnt++; if (!done) $display("FAIL wr_idle got busy want idle"); else pass_cnt++;
    total_cnt++; if (stb_count !== 1) $display("FAIL wr_stb_count got %0d want 1", stb_count); else pass_cnt++;
    total_cnt++; if (cap_rw !== 1'b1) $display("FAIL wr_rw got %0b want 1", cap_rw); else pass_cnt++;
    total_cnt++; if (cap_addr !== 32'h00000004) $display("FAIL wr_addr got %08h want 00000004", cap_addr); else pass_cnt++;
    total_cnt++; if (cap_dtw !== 32'h12345678) $display("FAIL wr_dtw got %08h want 12345678", cap_dtw); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'hA2)
      $display("FAIL wr_resp got %0d bytes first %02h want 1 byte A2", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;
  endtask

  task automatic test_grant_backpressure();
    logic [7:0] fr[9];
    logic [7:0] e_rsp[5];
    logic [31:0] e_addr, e_dtw;
    logic e_rw;
    int e_stb, e_n, end_cyc;
    bit done;
    fr = '{8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'h00, 8'h00, 8'h00, 8'h00};
    clear_obs(); gnt_delay = 10; ack_delay = 3; ack_dtr = $urandom; ready_mode = 1;
    send_frame(fr, 5);
    end_cyc = cyc;
    total_cnt++; if (dbg.o_req !== 1'b1) $display("FAIL gnt_req_at_frame_end got %0b want 1", dbg.o_req); else pass_cnt++;
    wait_idle(done);
    txn_id++;
    $display("txn %0d: cmd 01 under grant delay, stb %0d resp_bytes %0d", txn_id, stb_count, got_q.size());
    model_txn(fr, ack_delay, ack_dtr, e_stb, e_addr, e_dtw, e_rw, e_rsp, e_n);
    total_cnt++; if (!done) $display("FAIL gnt_idle got busy want idle"); else pass_cnt++;
    total_cnt++; if (stb_count !== 1) $display("FAIL gnt_stb_count got %0d want 1", stb_count); else pass_cnt++;
    total_cnt++; if (stb_cyc - end_cyc <= gnt_delay) $display("FAIL gnt_stb_early got %0d cycles want > %0d", stb_cyc - end_cyc, gnt_delay); else pass_cnt++;
    total_cnt++; if (cap_addr !== e_addr) $display("FAIL gnt_addr got %08h want %08h", cap_addr, e_addr); else pass_cnt++;
    total_cnt++; if (got_q.size() !== e_n) $display("FAIL gnt_resp_len got %0d want %0d", got_q.size(), e_n); else pass_cnt++;
    for (int i = 0; i < e_n && i < got_q.size(); i++) begin
      total_cnt++; if (got_q[i] !== e_rsp[i]) $display("FAIL gnt_resp_byte%0d got %02h want %02h", i, got_q[i], e_rsp[i]); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] fr[9] = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    int delays[3] = '{0, TO, TO + 1};
    bit done;
    for (int k = 0; k < 3; k++) begin
      clear_obs(); gnt_delay = 0; ack_delay = delays[k]; ack_dtr = 32'hC0FFEE11; ready_mode = 0;
      run_txn(fr, 5, done);
      total_cnt++; if (!done) $display("FAIL to_idle ack%0d got busy want idle", delays[k]); else pass_cnt++;
      total_cnt++; if (stb_count !== 1) $display("FAIL to_stb ack%0d got %0d want 1", delays[k], stb_count); else pass_cnt++;
      total_cnt++; if (req_drop_at !== TO) $display("FAIL to_req_drop ack%0d got %0d want %0d", delays[k], req_drop_at, TO); else pass_cnt++;
      if (delays[k] == TO) begin
        total_cnt++; if (got_q.size() !== 5 || got_q[0] !== 8'hA1 || got_q[4] !== 8'h11)
          $display("FAIL to_ack_edge_resp got %0d bytes first %02h want A1 .. 11", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
        else pass_cnt++;
      end else begin
        total_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'hEF)
          $display("FAIL to_resp ack%0d got %0d bytes first %02h want 1 byte EF", delays[k], got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_badcmd_drop();
    logic [7:0] fr[9] = '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] fr2[9] = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit done, seen;
    clear_obs(); gnt_delay = 0; ack_delay = 1; ready_mode = 0;
    run_txn(fr, 1, done);
    total_cnt++; if (!done) $display("FAIL bad_idle got busy want idle"); else pass_cnt++;
    total_cnt++; if (stb_count !== 0) $display("FAIL bad_stb got %0d want 0", stb_count); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 1 || got_q[0] !== 8'hEE)
      $display("FAIL bad_resp got %0d bytes first %02h want 1 byte EE", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;

    clear_obs(); ack_delay = 6; ack_dtr = 32'h01020304;
    send_frame(fr2, 5);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (stb_count > 0) begin seen = 1; break; end
    end
    total_cnt++; if (!seen) $display("FAIL drop_wait_stb got none want 1"); else pass_cnt++;
    @(posedge clk); #1; dbg.i_rx_data = 8'h02; dbg.i_rx_valid = 1'b1;
    @(posedge clk); #1; dbg.i_rx_valid = 1'b0;
    wait_idle(done);
    txn_id++;
    $display("txn %0d: cmd 01 with stray byte, drops %0d resp_bytes %0d", txn_id, drop_count, got_q.size());
    total_cnt++; if (drop_count !== 1) $display("FAIL drop_pulse got %0d want 1", drop_count); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 5 || got_q[0] !== 8'hA1 || got_q[4] !== 8'h04)
      $display("FAIL drop_resp got %0d bytes first %02h want A1 .. 04", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'h00);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (dbg.o_busy !== 1'b0) $display("FAIL drop_no_restart got busy %0b want 0", dbg.o_busy); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [7:0] fr[9] = '{8'h01, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] fr2[9] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00};
    bit done;
    clear_obs(); gnt_delay = 0; ack_delay = 3; ack_dtr = 32'hA5A55A5A; ready_mode = 0;
    send_frame(fr, 3);
    #2; reset_n = 1'b0; #1;
    total_cnt++; if (dbg.o_busy !== 1'b0) $display("FAIL arst_busy got %0b want 0", dbg.o_busy); else pass_cnt++;
    total_cnt++; if (dbg.o_addr !== 32'h0) $display("FAIL arst_addr got %08h want 0", dbg.o_addr); else pass_cnt++;
    total_cnt++; if (dbg.o_dtw !== 32'h0) $display("FAIL arst_dtw got %08h want 0", dbg.o_dtw); else pass_cnt++;
    total_cnt++; if ({dbg.o_req, dbg.o_stb, dbg.o_rw, dbg.o_tx_valid, dbg.o_rx_drop} !== 5'b0)
      $display("FAIL arst_ctrl got %05b want 00000", {dbg.o_req, dbg.o_stb, dbg.o_rw, dbg.o_tx_valid, dbg.o_rx_drop});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_obs();
    run_txn(fr2, 5, done);
    total_cnt++; if (!done) $display("FAIL arst_idle got busy want idle"); else pass_cnt++;
    total_cnt++; if (cap_addr !== 32'h00000120) $display("FAIL arst_addr_after got %08h want 00000120", cap_addr); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 5 || got_q[1] !== 8'hA5 || got_q[4] !== 8'h5A)
      $display("FAIL arst_resp got %0d bytes want A1 A5 A5 5A 5A", got_q.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] fr[9];
    logic [7:0] e_rsp[5];
    logic [31:0] e_addr, e_dtw;
    logic e_rw;
    int e_stb, e_n, n, sel;
    bit done;
    for (int t = 0; t < 16; t++) begin
      sel = $urandom_range(0, 5);
      for (int i = 0; i < 9; i++) fr[i] = 8'($urandom);
      if (sel < 3) begin fr[0] = 8'h01; n = 5; end
      else if (sel < 5) begin fr[0] = 8'h02; n = 9; end
      else begin fr[0] = 8'($urandom_range(3, 255)); n = 1; end
      clear_obs();
      gnt_delay = $urandom_range(0, 4); ack_delay = $urandom_range(0, TO + 2);
      ack_dtr = $urandom; ready_mode = 2;
      run_txn(fr, n, done);
      model_txn(fr, ack_delay, ack_dtr, e_stb, e_addr, e_dtw, e_rw, e_rsp, e_n);
      total_cnt++; if (!done) $display("FAIL rnd%0d_idle got busy want idle", t); else pass_cnt++;
      total_cnt++; if (stb_count !== e_stb) $display("FAIL rnd%0d_stb got %0d want %0d", t, stb_count, e_stb); else pass_cnt++;
      if (e_stb == 1) begin
        total_cnt++; if (cap_addr !== e_addr || cap_rw !== e_rw)
          $display("FAIL rnd%0d_addr got %08h/%0b want %08h/%0b", t, cap_addr, cap_rw, e_addr, e_rw);
        else pass_cnt++;
      end
      if (e_rw) begin
        total_cnt++; if (cap_dtw !== e_dtw) $display("FAIL rnd%0d_dtw got %08h want %08h", t, cap_dtw, e_dtw); else pass_cnt++;
      end
      total_cnt++; if (got_q.size() !== e_n) $display("FAIL rnd%0d_resp_len got %0d want %0d", t, got_q.size(), e_n); else pass_cnt++;
      for (int i = 0; i < e_n && i < got_q.size(); i++) begin
        total_cnt++; if (got_q[i] !== e_rsp[i]) $display("FAIL rnd%0d_byte%0d got %02h want %02h", t, i, got_q[i], e_rsp[i]); else pass_cnt++;
      end
      total_cnt++; if (drop_count !== 0) $display("FAIL rnd%0d_drop got %0d want 0", t, drop_count); else pass_cnt++;
    end
  endtask

  initial begin
    dbg.i_rx_data = 8'h00; dbg.i_rx_valid = 1'b0; dbg.i_tx_ready = 1'b1;
    dbg.i_gnt = 1'b0; dbg.i_ack = 1'b0; dbg.i_dtr = 32'h0;
    gnt_delay = 0; ack_delay = 0; ack_dtr = 32'h0; ready_mode = 0;
    req_hi = 0; since_stb = 0; cyc = 0; prev_stall = 0; prev_data = 8'h00;
    clear_obs();
    #1 reset_n = 1'b0;

    fork
      // Bus slave: grant after a programmable request delay, ack a programmable
      // number of cycles after the strobe, and record what the strobe carried.
      forever begin
        @(negedge clk);
        cyc++;
        if (pending_gnt) begin
          total_cnt++; if (dbg.o_stb !== 1'b1) $display("FAIL stb_after_gnt got %0b want 1", dbg.o_stb); else pass_cnt++;
        end else if (dbg.o_stb === 1'b1) begin
          total_cnt++; $display("FAIL stb_without_gnt got 1 want 0");
        end
        if (dbg.o_stb) begin
          stb_count++; stb_cyc = cyc;
          cap_addr = dbg.o_addr; cap_rw = dbg.o_rw; cap_dtw = dbg.o_dtw;
          ack_cd = ack_delay; since_stb = 0; watching = 1;
        end else if (watching) since_stb++;
        if (watching && !dbg.o_req) begin req_drop_at = since_stb; watching = 0; end
        pending_gnt = dbg.o_req && dbg.i_gnt && !watching && !dbg.o_stb;
        req_hi = dbg.o_req ? req_hi + 1 : 0;
        @(posedge clk); #1;
        dbg.i_ack = 1'b0;
        dbg.i_dtr = $urandom;
        if (ack_cd > 0) begin
          ack_cd--;
          if (ack_cd == 0) begin dbg.i_ack = 1'b1; dbg.i_dtr = ack_dtr; end
        end
        dbg.i_gnt = (gnt_delay == 0) || (req_hi >= gnt_delay);
      end
      // Transmit side: ready pattern generator.
      forever begin
        @(posedge clk); #1;
        case (ready_mode)
          1:       dbg.i_tx_ready = ~dbg.i_tx_ready;
          2:       dbg.i_tx_ready = 1'($urandom);
          default: dbg.i_tx_ready = 1'b1;
        endcase
      end
      // Transmit monitor: collect accepted bytes and check hold-under-stall.
      forever begin
        @(negedge clk);
        if (prev_stall) begin
          total_cnt++;
          if (dbg.o_tx_valid !== 1'b1 || dbg.o_tx_data !== prev_data)
            $display("FAIL tx_hold got %0b/%02h want 1/%02h", dbg.o_tx_valid, dbg.o_tx_data, prev_data);
          else pass_cnt++;
        end
        if (dbg.o_tx_valid && dbg.i_tx_ready) got_q.push_back(dbg.o_tx_data);
        prev_stall = dbg.o_tx_valid && !dbg.i_tx_ready;
        prev_data  = dbg.o_tx_data;
        if (dbg.o_rx_drop) drop_count++;
      end
    join_none

    test_reset();
    test_rd();
    test_wr();
    test_grant_backpressure();
    test_timeout();
    test_badcmd_drop();
    test_async_reset();
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/soc_dbg_master.md
Name: soc_dbg_master

Overview:
- Debug bus initiator: parses a byte-stream command protocol arriving from a UART receiver and issues single-word read/write cycles on the SoC stb/ack memory bus.
- It is a second initiator alongside the CPU. Access is requested through a req/gnt pair to an external arbiter in front of dev_intercon.
- Results are returned as a byte stream to a UART transmitter.
- Used for program loading and peek/poke of MMIO and BRAM.

Parameters:
TIMEOUT, 255, bus cycles to wait for i_ack after o_stb before aborting; 1..65535
TO_BITS, 16, width of timeout counter; must hold TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
i_rx_data  input  8  received byte
i_rx_valid  input  1  one-cycle pulse per received byte; no backpressure
o_tx_data  output  8  response byte
o_tx_valid  output  1  response byte valid; held until accepted
i_tx_ready  input  1  transmitter accepts when o_tx_valid & i_tx_ready
o_req  output  1  bus request to arbiter
i_gnt  input  1  bus grant; level, held while granted
o_stb  output  1  bus strobe, one-cycle pulse
o_rw  output  1  1 = write, 0 = read
o_addr  output  32  word address, bits [1:0] forced 0
o_dtw  output  32  write data
i_ack  input  1  one-cycle bus acknowledge
i_dtr  input  32  read data, valid in i_ack cycle
o_busy  output  1  high whenever state != IDLE
o_rx_drop  output  1  one-cycle pulse when a byte arrives in a non-receiving state

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; all outputs 0; addr/data shift registers 0; byte counter 0.
- Command frames, all multi-byte fields big-endian (MSB first):
  - 0x01 RD: 4 address bytes.
  - 0x02 WR: 4 address bytes, then 4 data bytes.
- Responses:
  - RD: 0xA1 followed by 4 data bytes, MSB first.
  - WR: 0xA2.
  - Unknown command: 0xEE.
  - Bus timeout: 0xEF; no data bytes follow, for both RD and WR.
- States:
  - IDLE: on i_rx_valid, latch cmd. 0x01/0x02 -> ADDR with cnt=0. Any other value -> RESP with 0xEE.
  - ADDR: each i_rx_valid shifts a byte into addr; after the 4th byte -> DATA if WR, else REQ.
  - DATA: 4 bytes shift into dtw -> REQ.
  - REQ: o_req=1. On the first cycle with i_gnt=1, o_stb=1 for exactly that cycle -> BUS. o_req stays high through BUS.
  - BUS: o_addr/o_rw/o_dtw stable. Timeout counter increments each cycle.
    - i_ack=1: capture i_dtr, load response, o_req=0 -> RESP.
    - Counter reaches TIMEOUT with no ack: o_req=0, load 0xEF -> RESP.
    - An ack arriving in the same cycle as the timeout wins.
  - RESP: present bytes on o_tx_data with o_tx_valid=1. Advance on each handshake. After the last handshake: o_tx_valid=0 -> IDLE.
- Latency: o_stb is asserted on the cycle after i_gnt is first sampled high in REQ. i_gnt already high on REQ entry -> o_stb on the next cycle. Response byte is valid the cycle after ack.
- i_rx_valid in REQ/BUS/RESP: byte discarded, o_rx_drop pulses, state unchanged.
- i_gnt falling during BUS: ignored; the cycle completes. The arbiter must not revoke a grant mid-cycle.
- i_ack outside BUS: ignored.
- o_tx_valid never drops before its handshake; o_tx_data is stable while o_tx_valid & !i_tx_ready.
- reset_n asserted mid-frame or mid-bus-cycle: immediate return to reset values. A partially received frame is lost.
- No inter-byte timeout; the host resynchronises by pulsing reset_n or by completing the frame.

Decomposition:
- Shared package/header holds:
  - command codes CMD_RD=8'h01, CMD_WR=8'h02;
  - response codes RSP_RD=8'hA1, RSP_WR=8'hA2, RSP_BADCMD=8'hEE, RSP_TIMEOUT=8'hEF;
  - state encoding localparams IDLE/ADDR/DATA/REQ/BUS/RESP.
- One natural sub-module, soc_dbg_txser: loads a 40-bit response plus a byte count (1 or 5) and serialises it MSB-first on the valid/ready tx interface, with a done pulse.

Test Plan:
- RD: rx 01 00 00 80 10, gnt=1, ack after 2 cycles with dtr=32'hDEADBEEF.
  -> exactly one stb, o_rw=0, o_addr=32'h00008010; tx A1 DE AD BE EF.
- WR: rx 02 00 00 00 07 12 34 56 78.
  -> o_addr=32'h00000004 (low bits masked), o_rw=1, o_dtw=32'h12345678; tx A2.
- Grant and backpressure: gnt held low 10 cycles, then high; i_tx_ready toggled every other cycle.
  -> o_req high from frame end; stb only after gnt; tx bytes unchanged and not duplicated.
- Timeout: TIMEOUT=8, never ack.
  -> stb once; o_req drops on the 8th wait cycle; tx EF only.
  - Also ack exactly on cycle 8 -> normal A1 response.
- Bad command and drops: rx 0x55 -> tx EE.
  - Extra rx byte during BUS -> o_rx_drop pulse, response unaffected.
- Async reset mid-frame: reset_n low after 2 address bytes, then a full RD frame.
  -> outputs 0 during reset; the new frame executes normally.
